regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised integer register file with a per-register pending-write scoreboard for the pipelined core.
- N combinational read ports, one synchronous write-back port, one issue port.
- The issue port reserves a destination register. Write-back releases the reservation.
- Decode uses the busy flags and issue_ready to stall.
- Register 0 is hardwired to zero. A debug tap exposes one register, a0 by default.

Parameters:
- DATA_WIDTH, 32: register width in bits.
- ADDR_WIDTH, 5: address width; the file holds 2**ADDR_WIDTH registers, including x0.
- NUM_READ, 2: number of read ports.
- PEND_WIDTH, 2: width of each pending-write counter; at most 2**PEND_WIDTH-1 writes in flight per register.
- DBG_REG, 10: index of the register driven on dbg_data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_READ*ADDR_WIDTH  read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NUM_READ*DATA_WIDTH  read data, same packing as rd_addr.
- rd_busy  out  NUM_READ  per read port, 1 = the addressed register has a write outstanding.
- wr_en  in  1  write-back strobe.
- wr_addr  in  ADDR_WIDTH  write-back destination.
- wr_data  in  DATA_WIDTH  write-back data.
- issue_en  in  1  reserve issue_addr; honoured only when issue_ready=1.
- issue_addr  in  ADDR_WIDTH  register to reserve.
- issue_ready  out  1  0 when the counter for issue_addr is saturated.
- dbg_data  out  DATA_WIDTH  registered contents of DBG_REG.

Behaviour:
- Reset: one clk, synchronous, active-high.
  - All data registers are cleared to 0 and all pending counters to 0.
  - Outputs after reset: rd_data=0, rd_busy=0, issue_ready=1, dbg_data=0.
  - rst has priority over wr_en and issue_en in the same cycle.
  - Reset asserted while writes are in flight discards all reservations; late write-backs are then treated as unreserved writes.
- Storage: 2**ADDR_WIDTH-1 physical registers, for indices 1..max.
  - x0 is not stored.
  - Reads of address 0 return 0.
  - Writes and issues to address 0 are ignored.
  - The x0 counter is never instantiated and is always 0.
- Write: when wr_en=1 and wr_addr!=0, the register takes wr_data at the rising edge. Latency is 1 cycle.
- Read: rd_data is combinational from stored state (without the optional feature). A read in the same cycle as a write to the same address returns the old value.
- Counter cnt[r] update, one clk per cycle:
  - Issue accepted (issue_en && issue_ready && issue_addr!=0): +1.
  - Write-back (wr_en && wr_addr!=0 && cnt[wr_addr]!=0): -1.
  - Both events to the same register: no change (net 0).
  - Write-back with cnt=0: data is still written and the counter stays 0 (no underflow).
- issue_ready = (cnt[issue_addr] != max) || (issue_addr==0).
  - Combinational, from stored state only.
  - issue_en with issue_ready=0 is dropped: no counter change.
- rd_busy[i] = (cnt[rd_addr_i] != 0), combinational from stored state.
- dbg_data: registered copy of DBG_REG.
  - Updated on the same edge as a write to DBG_REG, so dbg_data equals the register's stored value.
  - Must not expose any bypassed value.
- Widths: counters are unsigned PEND_WIDTH-bit values and never wrap.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Same-cycle write-to-read forwarding: if wr_en && wr_addr!=0 && wr_addr==rd_addr_i, then rd_data_i = wr_data.
  - rd_busy_i is forced to 0 when that write-back would bring cnt[rd_addr_i] from 1 to 0 this cycle with no same-cycle issue to that register.
- Undefined: read-old-value semantics and busy from stored state only, as above.
- issue_ready and dbg_data are unaffected either way.

Decomposition:
- Package regfile_pkg:
  - Defaults DATA_WIDTH_DEF, ADDR_WIDTH_DEF.
  - ZERO_REG = 0 and A0_REG = 10.
  - typedefs reg_addr_t (logic [ADDR_WIDTH_DEF-1:0]) and reg_data_t.
- One sub-module, regfile_scoreboard: holds the counter array, issue_ready and raw busy lookup.
  - Instantiated once.
  - Data storage and read muxing stay in regfile_sb.

Test Plan:
- Reset then read: rst=1 for 1 cycle, then read x1 and x31 -> rd_data=0, rd_busy=0, issue_ready=1, dbg_data=0.
- x0 protection: wr_en=1, wr_addr=0, wr_data=0xDEADBEEF; issue_addr=0 -> read x0 returns 0, rd_busy=0, issue_ready=1.
- Write then read, plus debug tap: write x10=0x12345678 -> next cycle rd_data=0x12345678 and dbg_data=0x12345678. In the write cycle, rd_data is the old value 0 without the macro and 0x12345678 with REGFILE_BYPASS_EN; dbg_data is 0 in both builds.
- Scoreboard saturation, PEND_WIDTH=2: issue x5 three times -> rd_busy=1 and issue_ready=0 for x5. A fourth issue_en is dropped: one write-back brings issue_ready to 1, and busy clears only after three write-backs.
- Simultaneous events: cnt[x7]=1 with issue and write-back to x7 in the same cycle -> cnt stays 1, rd_busy=1, data written. A write-back to x8 with cnt=0 writes data, cnt stays 0, rd_busy=0.
- Reset mid-flight: cnt[x3]=2, assert rst -> rd_busy=0, x3 reads 0. A late write-back of 0xAA to x3 writes 0xAA and cnt stays 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the regfile_sb register file and scoreboard.
package regfile_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    // Architectural register indices with fixed meaning.
    localparam int ZERO_REG = 0;
    localparam int A0_REG   = 10;

    typedef logic [ADDR_WIDTH_DEF-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, write-back port, issue port and debug tap.
// The core side uses the master modport; the register file uses slave.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_READ   = 2
) ();

    logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_READ*DATA_WIDTH-1:0] rd_data;
    logic [NUM_READ-1:0]            rd_busy;
    logic                           wr_en;
    logic [ADDR_WIDTH-1:0]          wr_addr;
    logic [DATA_WIDTH-1:0]          wr_data;
    logic                           issue_en;
    logic [ADDR_WIDTH-1:0]          issue_addr;
    logic                           issue_ready;
    logic [DATA_WIDTH-1:0]          dbg_data;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        input  rd_data, rd_busy, issue_ready, dbg_data
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        output rd_data, rd_busy, issue_ready, dbg_data
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one saturating counter per register x1..max.
// Issue reserves a register, write-back releases it; x0 has no counter.
// With REGFILE_BYPASS_EN defined, also reports which read ports see a
// counter of exactly one, so the top can clear busy on the releasing edge.
module regfile_scoreboard #(
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH_DEF,
    parameter int NUM_READ   = 2,
    parameter int PEND_WIDTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en_i,
    input  logic [ADDR_WIDTH-1:0]          wr_addr_i,
    input  logic                           issue_en_i,
    input  logic [ADDR_WIDTH-1:0]          issue_addr_i,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_READ-1:0]            rd_busy_o,
`ifdef REGFILE_BYPASS_EN
    output logic [NUM_READ-1:0]            rd_last_o,
`endif
    output logic                           issue_ready_o
);

    localparam int NREG = 2**ADDR_WIDTH;
    localparam logic [PEND_WIDTH-1:0] CNT_MAX = '1;

    logic [PEND_WIDTH-1:0] cnt_q    [1:NREG-1];
    logic [PEND_WIDTH-1:0] cnt_d    [1:NREG-1];
    logic [PEND_WIDTH-1:0] cnt_view [0:NREG-1];
    logic                  issue_acc;
    logic                  wb_dec;

    // Address-indexed view of the counters with x0 tied to zero.
    always_comb begin
        cnt_view[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_view[r] = cnt_q[r];
        end
    end

    assign issue_ready_o = (cnt_view[issue_addr_i] != CNT_MAX);
    assign issue_acc     = issue_en_i && issue_ready_o && (issue_addr_i != '0);
    // A write-back to an unreserved register still writes data but must not underflow.
    assign wb_dec        = wr_en_i && (wr_addr_i != '0) && (cnt_view[wr_addr_i] != '0);

    // Next counter values: +1 on accepted issue, -1 on release, net zero on both.
    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
            cnt_d[r] = cnt_q[r];
            if (issue_acc && (issue_addr_i == ADDR_WIDTH'(r)) &&
                !(wb_dec && (wr_addr_i == ADDR_WIDTH'(r)))) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (wb_dec && (wr_addr_i == ADDR_WIDTH'(r)) &&
                         !(issue_acc && (issue_addr_i == ADDR_WIDTH'(r)))) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    // Counter registers; reset discards every outstanding reservation.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so all flops update from the same pre-edge values.
        if (rst) begin
            // NOTE: this array is reset by loop because reservations must not survive reset; arrays that need no defined start value are better left unreset.
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Per-read-port lookup of the stored counters.
    for (genvar i = 0; i < NUM_READ; i++) begin : g_busy
        logic [ADDR_WIDTH-1:0] addr;
        assign addr         = rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign rd_busy_o[i] = (cnt_view[addr] != '0);
`ifdef REGFILE_BYPASS_EN
        assign rd_last_o[i] = (cnt_view[addr] == PEND_WIDTH'(1));
`endif
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with pending-write scoreboard and debug tap.
// x0 is hardwired to zero; dbg_data is a registered copy of DBG_REG.
// Optional macro REGFILE_BYPASS_EN: forward same-cycle write-back data to
// reads and clear busy on the write-back that releases the last reservation.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_READ   = 2,
    parameter int PEND_WIDTH = 2,
    parameter int DBG_REG    = A0_REG
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);

    localparam int NREG = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] DBG_ADDR = ADDR_WIDTH'(DBG_REG);

    logic [DATA_WIDTH-1:0] regs_q [1:NREG-1];
    logic [DATA_WIDTH-1:0] dbg_q;
    logic [DATA_WIDTH-1:0] dbg_d;
    logic [NUM_READ-1:0]   busy_raw;
    logic                  wr_fire;
`ifdef REGFILE_BYPASS_EN
    logic [NUM_READ-1:0]   rd_last;
    logic                  issue_acc;
`endif

    assign wr_fire = bus.wr_en && (bus.wr_addr != '0);

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_READ   (NUM_READ),
        .PEND_WIDTH (PEND_WIDTH)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .wr_en_i       (bus.wr_en),
        .wr_addr_i     (bus.wr_addr),
        .issue_en_i    (bus.issue_en),
        .issue_addr_i  (bus.issue_addr),
        .rd_addr_i     (bus.rd_addr),
        .rd_busy_o     (busy_raw),
`ifdef REGFILE_BYPASS_EN
        .rd_last_o     (rd_last),
`endif
        .issue_ready_o (bus.issue_ready)
    );

    // Register storage for x1..max; reset clears every register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_fire) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Debug tap follows the stored value of DBG_REG, never a forwarded one.
    always_comb begin
        dbg_d = dbg_q;
        if (wr_fire && (bus.wr_addr == DBG_ADDR)) begin
            dbg_d = bus.wr_data;
        end
    end

    // Debug tap register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_q <= '0;
        end else begin
            dbg_q <= dbg_d;
        end
    end

    assign bus.dbg_data = dbg_q;

`ifdef REGFILE_BYPASS_EN
    assign issue_acc = bus.issue_en && bus.issue_ready && (bus.issue_addr != '0);
`endif

    // Read ports: combinational mux over stored registers, x0 reads zero.
    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] stored;
        assign addr   = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign stored = (addr == '0) ? '0 : regs_q[addr];
`ifdef REGFILE_BYPASS_EN
        logic fwd;
        assign fwd = wr_fire && (bus.wr_addr == addr);
        assign bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = fwd ? bus.wr_data : stored;
        assign bus.rd_busy[i] = busy_raw[i] &&
            !(fwd && rd_last[i] && !(issue_acc && (bus.issue_addr == addr)));
`else
        assign bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = stored;
        assign bus.rd_busy[i] = busy_raw[i];
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table plus hand-written
// sequences for reset, write latency, saturation, simultaneous events and
// reset with writes in flight.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    regfile_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) bus ();

    regfile_sb #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .NUM_READ   (2),
        .PEND_WIDTH (2),
        .DBG_REG    (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic      we;
        reg_addr_t wa;
        reg_data_t wd;
        logic      ie;
        reg_addr_t ia_in;
        reg_addr_t ra0;
        reg_addr_t ra1;
        reg_addr_t ia_chk;
        reg_data_t e_d0;
        reg_data_t e_d1;
        logic      e_b0;
        logic      e_b1;
        logic      e_rdy;
        reg_data_t e_dbg;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input reg_addr_t wa, input reg_data_t wd,
                         input logic ie, input reg_addr_t ia);
        bus.wr_en      = we;
        bus.wr_addr    = wa;
        bus.wr_data    = wd;
        bus.issue_en   = ie;
        bus.issue_addr = ia;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic set_rd(input reg_addr_t a0, input reg_addr_t a1);
        bus.rd_addr = {a1, a0};
    endtask

    // Advance past the next rising edge, then clear the strobes.
    task automatic cycle();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    function automatic reg_data_t rd0();
        return bus.rd_data[31:0];
    endfunction

    function automatic reg_data_t rd1();
        return bus.rd_data[63:32];
    endfunction

    // Check port-0 data/busy and issue_ready for one register.
    task automatic probe(input string nm, input reg_addr_t a, input reg_data_t ed,
                         input logic eb, input logic erdy);
        set_rd(a, '0);
        bus.issue_addr = a;
        #1;
        check({nm, " data"}, rd0(), ed);
        check({nm, " busy"}, 32'(bus.rd_busy[0]), 32'(eb));
        check({nm, " ready"}, 32'(bus.issue_ready), 32'(erdy));
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd1,  32'h1111_1111, 1'b0, 5'd0, 5'd1,  5'd2,  5'd1,
                    32'h1111_1111, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678};
        vecs[1] = '{1'b1, 5'd31, 32'hFFFF_0001, 1'b1, 5'd4, 5'd31, 5'd4,  5'd4,
                    32'hFFFF_0001, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1234_5678};
        vecs[2] = '{1'b1, 5'd10, 32'hA0A0_A0A0, 1'b0, 5'd0, 5'd10, 5'd0,  5'd0,
                    32'hA0A0_A0A0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA0A0_A0A0};
        vecs[3] = '{1'b1, 5'd4,  32'h0000_0044, 1'b0, 5'd0, 5'd4,  5'd1,  5'd4,
                    32'h0000_0044, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 32'hA0A0_A0A0};
        vecs[4] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 1'b1, 5'd0, 5'd0,  5'd31, 5'd0,
                    32'h0, 32'hFFFF_0001, 1'b0, 1'b0, 1'b1, 32'hA0A0_A0A0};
        vecs[5] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd2, 5'd2,  5'd4,  5'd2,
                    32'h0, 32'h0000_0044, 1'b1, 1'b0, 1'b1, 32'hA0A0_A0A0};
        vecs[6] = '{1'b1, 5'd2,  32'h2222_2222, 1'b0, 5'd0, 5'd2,  5'd10, 5'd2,
                    32'h2222_2222, 32'hA0A0_A0A0, 1'b0, 1'b0, 1'b1, 32'hA0A0_A0A0};

        // Reset then read.
        rst = 1'b1;
        idle();
        set_rd(5'd1, 5'd31);
        cycle();
        rst = 1'b0;
        set_rd(5'd1, 5'd31);
        bus.issue_addr = 5'd1;
        #1;
        check("reset rd_data x1", rd0(), 32'h0);
        check("reset rd_data x31", rd1(), 32'h0);
        check("reset rd_busy", 32'(bus.rd_busy), 32'h0);
        check("reset issue_ready", 32'(bus.issue_ready), 32'h1);
        check("reset dbg_data", bus.dbg_data, 32'h0);

        // Write x10 with the debug tap; read in the write cycle, then after.
        drive(1'b1, 5'd10, 32'h1234_5678, 1'b0, '0);
        set_rd(5'd10, 5'd0);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("write-cycle read x10", rd0(), 32'h1234_5678);
`else
        check("write-cycle read x10", rd0(), 32'h0);
`endif
        check("write-cycle dbg_data", bus.dbg_data, 32'h0);
        cycle();
        check("after-write read x10", rd0(), 32'h1234_5678);
        check("after-write dbg_data", bus.dbg_data, 32'h1234_5678);

        // Directed vector table: one write/issue cycle, then read back.
        for (int v = 0; v < 7; v++) begin
            drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ie, vecs[v].ia_in);
            cycle();
            set_rd(vecs[v].ra0, vecs[v].ra1);
            bus.issue_addr = vecs[v].ia_chk;
            #1;
            check($sformatf("vec%0d rd_data0", v), rd0(), vecs[v].e_d0);
            check($sformatf("vec%0d rd_data1", v), rd1(), vecs[v].e_d1);
            check($sformatf("vec%0d rd_busy0", v), 32'(bus.rd_busy[0]), 32'(vecs[v].e_b0));
            check($sformatf("vec%0d rd_busy1", v), 32'(bus.rd_busy[1]), 32'(vecs[v].e_b1));
            check($sformatf("vec%0d issue_ready", v), 32'(bus.issue_ready), 32'(vecs[v].e_rdy));
            check($sformatf("vec%0d dbg_data", v), bus.dbg_data, vecs[v].e_dbg);
        end

        // Scoreboard saturation on x5.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, '0, 1'b1, 5'd5);
            #1;
            check($sformatf("sat ready before issue %0d", k), 32'(bus.issue_ready), 32'h1);
            cycle();
        end
        probe("sat full x5", 5'd5, 32'h0, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 5'd5);
        cycle();
        probe("sat dropped x5", 5'd5, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 5'd5, 32'h0000_0051, 1'b0, '0);
        cycle();
        probe("sat wb1 x5", 5'd5, 32'h0000_0051, 1'b1, 1'b1);
        drive(1'b1, 5'd5, 32'h0000_0052, 1'b0, '0);
        cycle();
        probe("sat wb2 x5", 5'd5, 32'h0000_0052, 1'b1, 1'b1);
        drive(1'b1, 5'd5, 32'h0000_0053, 1'b0, '0);
        cycle();
        probe("sat wb3 x5", 5'd5, 32'h0000_0053, 1'b0, 1'b1);

        // Simultaneous issue and write-back on x7 with one outstanding.
        drive(1'b0, '0, '0, 1'b1, 5'd7);
        cycle();
        drive(1'b1, 5'd7, 32'h0000_0077, 1'b1, 5'd7);
        cycle();
        probe("simul x7", 5'd7, 32'h0000_0077, 1'b1, 1'b1);
        drive(1'b1, 5'd7, 32'h0000_0078, 1'b0, '0);
        cycle();
        probe("simul x7 release", 5'd7, 32'h0000_0078, 1'b0, 1'b1);

        // Write-back to x8 with nothing outstanding: no underflow.
        drive(1'b1, 5'd8, 32'h0000_0088, 1'b0, '0);
        cycle();
        probe("unreserved wb x8", 5'd8, 32'h0000_0088, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b1, 5'd8);
        cycle();
        probe("issue after wb x8", 5'd8, 32'h0000_0088, 1'b1, 1'b1);

        // Reset with two writes in flight to x3; rst beats same-cycle wr/issue.
        drive(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd3);
        cycle();
        drive(1'b0, '0, '0, 1'b1, 5'd3);
        cycle();
        probe("inflight x3", 5'd3, 32'h0000_0033, 1'b1, 1'b1);
        rst = 1'b1;
        drive(1'b1, 5'd3, 32'h0000_0055, 1'b1, 5'd3);
        cycle();
        rst = 1'b0;
        probe("post-reset x3", 5'd3, 32'h0, 1'b0, 1'b1);
        check("post-reset dbg_data", bus.dbg_data, 32'h0);
        drive(1'b1, 5'd3, 32'h0000_00AA, 1'b0, '0);
        cycle();
        probe("late wb x3", 5'd3, 32'h0000_00AA, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b1, 5'd3);
        cycle();
        probe("reissue x3", 5'd3, 32'h0000_00AA, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
